// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: input conditioning and sequencing for the LED pattern datapath.
// Buttons and switches are synchronized, buttons are debounced and turned into
// single-cycle rising-edge events. Those events step the pattern-mode FSM and
// load the colour register. A programmable divider produces the step tick.
//
// o_valid is a one-cycle strobe with no ready/back-pressure: the pattern engines
// must advance exactly once for every cycle in which o_valid is high.
module led_seq_ctrl #(
    parameter int NB_BTN          = 4,
    parameter int NB_SW           = 4,
    parameter int NB_DEBOUNCE     = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNTER      = 32,
    parameter int BASE_PERIOD     = 1000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic              o_valid,
    output logic [1:0]        o_mode,
    output logic [1:0]        o_color,
    output logic              o_reverse,
    output logic              o_clear,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_SHIFT2 = 2'b10
    } mode_e;

    localparam logic [NB_DEBOUNCE-1:0] DB_LAST  = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_DEBOUNCE-1:0] DB_ONE   = NB_DEBOUNCE'(1);
    localparam logic [NB_COUNTER-1:0]  TICK_BASE = NB_COUNTER'(BASE_PERIOD);
    localparam logic [NB_COUNTER-1:0]  TICK_ONE  = NB_COUNTER'(1);

    logic [NB_BTN-1:0]      btn_meta;
    logic [NB_BTN-1:0]      btn_sync;
    logic [NB_SW-1:0]       sw_meta;
    logic [NB_SW-1:0]       sw_sync;
    logic [NB_DEBOUNCE-1:0] db_cnt [NB_BTN];
    logic [NB_BTN-1:0]      btn_stable;
    logic [NB_BTN-1:0]      btn_stable_d;
    mode_e                  mode_q;
    mode_e                  mode_d;
    logic [1:0]             color_q;
    logic [1:0]             color_d;
    logic                   clear_q;
    logic                   rev_q;
    logic [2:0]             sel_prev;
    logic                   sel_chg;
    logic [NB_COUNTER-1:0]  period_last;
    logic [NB_COUNTER-1:0]  cnt_tick;

    // Two-flop synchronizers for the asynchronous buttons and switches.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
        end
    end

    // Per-button debounce: a new level is accepted only after it has been seen
    // for DEBOUNCE_CYCLES consecutive synchronized cycles.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_stable <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_BTN; i++) begin
                if (btn_sync[i] == btn_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_stable[i] <= btn_sync[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Registered rising-edge events of the debounced buttons; release is silent.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_stable_d <= '0;
            o_btn_pulse  <= '0;
        end else begin
            btn_stable_d <= btn_stable;
            o_btn_pulse  <= btn_stable & ~btn_stable_d;
        end
    end

    // Mode/colour registers; o_clear marks the first cycle of a new mode.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q  <= MODE_FLASH;
            color_q <= 2'b00;
            clear_q <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            color_q <= color_d;
            clear_q <= o_btn_pulse[0];
            rev_q   <= sw_sync[3];
        end
    end

    // Next mode on a mode event (FLASH->SHIFT->SHIFT2->FLASH); lowest colour
    // button wins when several colour events coincide.
    always_comb begin
        mode_d  = mode_q;
        color_d = color_q;
        if (o_btn_pulse[0]) begin
            case (mode_q)
                MODE_FLASH: mode_d = MODE_SHIFT;
                MODE_SHIFT: mode_d = MODE_SHIFT2;
                default:    mode_d = MODE_FLASH;
            endcase
        end
        if (o_btn_pulse[1]) begin
            color_d = 2'b00;
        end else if (o_btn_pulse[2]) begin
            color_d = 2'b01;
        end else if (o_btn_pulse[3]) begin
            color_d = 2'b10;
        end
    end

    // Tick period from the speed switches; a speed change suppresses the tick.
    always_comb begin
        period_last = (TICK_BASE << sw_sync[2:0]) - TICK_ONE;
        sel_chg     = (sw_sync[2:0] != sel_prev);
        o_valid     = (cnt_tick == period_last) && !sel_chg;
    end

    // Tick counter: restarts on a speed change or a mode event, else wraps.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sel_prev <= 3'b000;
            cnt_tick <= '0;
        end else begin
            sel_prev <= sw_sync[2:0];
            if (sel_chg || o_btn_pulse[0]) begin
                cnt_tick <= '0;
            end else if (cnt_tick == period_last) begin
                cnt_tick <= '0;
            end else begin
                cnt_tick <= cnt_tick + TICK_ONE;
            end
        end
    end

    assign o_mode    = mode_q;
    assign o_color   = color_q;
    assign o_clear   = clear_q;
    assign o_reverse = rev_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: randomized and directed button/switch stimulus, a
// history-based reference model, and an event scoreboard checked at negedge.
`timescale 1ns/1ps
module tb_led_seq_ctrl;

    localparam int DC   = 4;
    localparam int BP   = 4;
    localparam int MAXC = 8192;
    localparam int W    = 43;

    logic       clock;
    logic       i_reset;
    logic [3:0] i_btn;
    logic [3:0] i_sw;
    logic       o_valid;
    logic [1:0] o_mode;
    logic [1:0] o_color;
    logic       o_reverse;
    logic       o_clear;
    logic [3:0] o_btn_pulse;

    led_seq_ctrl #(
        .NB_BTN(4), .NB_SW(4), .NB_DEBOUNCE(8), .DEBOUNCE_CYCLES(DC),
        .NB_COUNTER(32), .BASE_PERIOD(BP)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_btn(i_btn), .i_sw(i_sw),
        .o_valid(o_valid), .o_mode(o_mode), .o_color(o_color),
        .o_reverse(o_reverse), .o_clear(o_clear), .o_btn_pulse(o_btn_pulse)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    // Record: {cycle[31:0], valid, clear, pulse[3:0], mode[1:0], color[1:0], rev}
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;

    // ---------------- reference model state ----------------
    logic [3:0] raw_b [MAXC];
    logic [3:0] raw_s [MAXC];
    logic [3:0] stab  [MAXC];
    int         presses;
    int         epoch;
    logic [1:0] m_color;
    logic [1:0] m_mode_prev;
    logic [1:0] m_color_prev;
    logic       m_rev_prev;
    logic [3:0] cur_sw;

    // Raw value sampled by the DUT at edge j (nothing before the first edge).
    function automatic logic [3:0] rb(input int j);
        if (j < 1) return 4'b0000;
        return raw_b[j];
    endfunction

    function automatic logic [3:0] rs(input int j);
        if (j < 1) return 4'b0000;
        return raw_s[j];
    endfunction

    // Debounced level after edge j.
    function automatic logic [3:0] sv(input int j);
        if (j < 1) return 4'b0000;
        return stab[j];
    endfunction

    task automatic model_init();
        cyc          = 0;
        presses      = 0;
        epoch        = 0;
        m_color      = 2'b00;
        m_mode_prev  = 2'b00;
        m_color_prev = 2'b00;
        m_rev_prev   = 1'b0;
    endtask

    // Expected outputs for the cycle after edge cyc, from input history:
    // synced(k) = raw(k-1); a level is accepted after DC consecutive synced
    // samples differing from the accepted level; events lag by one cycle each.
    task automatic model_edge(input logic [3:0] btn, input logic [3:0] sw);
        logic [3:0] st_prev, nst, sy, pulse, pp, s1, s2, s3;
        logic [1:0] mode;
        logic       rev, valid;
        int         per;
        cyc = cyc + 1;
        if (cyc >= MAXC) begin
            $display("FAIL model_capacity: cycle %0d required below %0d", cyc, MAXC);
            n_err++;
            $fatal(1, "model history exhausted");
        end
        raw_b[cyc] = btn;
        raw_s[cyc] = sw;
        st_prev = sv(cyc - 1);
        nst     = st_prev;
        for (int i = 0; i < 4; i++) begin
            logic run;
            run = 1'b1;
            for (int j = 1; j <= DC; j++) begin
                sy = rb(cyc - j - 1);
                if (sy[i] == st_prev[i]) run = 1'b0;
            end
            if (run) nst[i] = ~st_prev[i];
        end
        stab[cyc] = nst;
        pulse = sv(cyc - 1) & ~sv(cyc - 2);
        pp    = sv(cyc - 2) & ~sv(cyc - 3);
        if (pp[0]) presses++;
        mode = 2'(presses % 3);
        if (pp[1])      m_color = 2'b00;
        else if (pp[2]) m_color = 2'b01;
        else if (pp[3]) m_color = 2'b10;
        s1  = rs(cyc - 1);
        s2  = rs(cyc - 2);
        s3  = rs(cyc - 3);
        rev = s2[3];
        if (pp[0] || (s2[2:0] != s3[2:0])) epoch = cyc;
        per   = BP << s1[2:0];
        valid = (((cyc - epoch) % per) == per - 1) && (s1[2:0] == s2[2:0]);
        if (valid || pp[0] || (pulse != 4'b0000) || (mode != m_mode_prev) ||
            (m_color != m_color_prev) || (rev != m_rev_prev)) begin
            exp_q.push_back({32'(cyc), valid, pp[0], pulse, mode, m_color, rev});
        end
        m_mode_prev  = mode;
        m_color_prev = m_color;
        m_rev_prev   = rev;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [3:0] btn);
        i_btn = btn;
        i_sw  = cur_sw;
        @(posedge clock);
        #1;
        model_edge(btn, cur_sw);
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        repeat (hold) step(mask);
        repeat (gap) step(4'b0000);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Any expected event still queued once its cycle has been observed was missed.
    task automatic flush_check();
        logic [W-1:0] e;
        @(negedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missed_event: cycle %0d got no event, required v/c/pulse/mode/color/rev=%b",
                     int'(e[42:11]), e[10:0]);
        end
    endtask

    // Asynchronous reset, checked before the next clock edge; release after an edge.
    task automatic do_reset(input logic [3:0] btn_hold);
        #1;
        i_reset = 1'b0;
        i_btn   = btn_hold;
        #1;
        check("reset_valid", 4'(o_valid), 4'h0);
        check("reset_mode", 4'(o_mode), 4'h0);
        check("reset_color", 4'(o_color), 4'h0);
        check("reset_clear", 4'(o_clear), 4'h0);
        check("reset_reverse", 4'(o_reverse), 4'h0);
        check("reset_pulse", o_btn_pulse, 4'h0);
        repeat (3) @(posedge clock);
        #1;
        i_reset = 1'b1;
        model_init();
    endtask

    // ---------------- monitor ----------------
    logic [1:0] d_mode_prev  = 2'b00;
    logic [1:0] d_color_prev = 2'b00;
    logic       d_rev_prev   = 1'b0;

    always @(negedge clock) begin
        logic [W-1:0] e;
        logic [10:0]  got;
        logic         ev;
        if (i_reset) begin
            while (exp_q.size() > 0 && int'(exp_q[0][42:11]) < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_event: cycle %0d got no event, required v/c/pulse/mode/color/rev=%b",
                         int'(e[42:11]), e[10:0]);
            end
            ev = o_valid || o_clear || (o_btn_pulse != 4'b0000) || (o_mode != d_mode_prev) ||
                 (o_color != d_color_prev) || (o_reverse != d_rev_prev);
            if (ev) begin
                got = {o_valid, o_clear, o_btn_pulse, o_mode, o_color, o_reverse};
                n_vec++;
                if (exp_q.size() > 0 && int'(exp_q[0][42:11]) == cyc) begin
                    e = exp_q.pop_front();
                    if (got !== e[10:0]) begin
                        n_err++;
                        $display("FAIL event_cycle_%0d: got v/c/pulse/mode/color/rev=%b required %b",
                                 cyc, got, e[10:0]);
                    end
                end else begin
                    n_err++;
                    $display("FAIL unexpected_event: cycle %0d got v/c/pulse/mode/color/rev=%b required no event",
                             cyc, got);
                end
            end
        end
        d_mode_prev  = o_mode;
        d_color_prev = o_color;
        d_rev_prev   = o_reverse;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        i_reset = 1'b1;
        i_btn   = 4'b0000;
        i_sw    = 4'b0000;
        cur_sw  = 4'b0000;
        model_init();
        do_reset(4'b0000);

        // Idle: ticks every BP cycles.
        repeat (12) step(4'b0000);

        // Mode button, three clean presses: 01, 10, 00.
        repeat (3) press(4'b0001, 20, 10);

        // Glitch on green shorter than the debounce window, then a real press.
        press(4'b0100, 3, 10);
        press(4'b0100, 10, 10);

        // Red and blue together: red wins. Mode and blue together: both apply.
        press(4'b1010, 10, 10);
        press(4'b1001, 10, 10);

        // Speed 3, then back to 0 mid-period; reverse toggled.
        cur_sw = 4'b0011;
        repeat (80) step(4'b0000);
        cur_sw = 4'b1000;
        repeat (20) step(4'b0000);

        // Randomized buttons and switches with mixed hold lengths.
        for (int s = 0; s < 260; s++) begin
            logic [3:0] b;
            int         hold;
            b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) b = 4'b0000;
            if ($urandom_range(0, 3) == 0) cur_sw = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 2))};
            hold = $urandom_range(1, 12);
            repeat (hold) step(b);
        end

        // Bring the block to mode 10 / colour 10, then reset mid-period.
        cur_sw = 4'b1001;
        repeat (20) step(4'b0000);
        n = (2 - (presses % 3) + 3) % 3;
        repeat (n) press(4'b0001, 10, 10);
        press(4'b1000, 10, 10);
        repeat ($urandom_range(2, 9)) step(4'b0000);
        flush_check();
        do_reset(4'b0010);

        // Red held through reset release yields a pulse after debounce.
        repeat (12) step(4'b0010);
        repeat (30) step(4'b0000);
        flush_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Control/sequencing block for the LED pattern datapath (flash, shift-register, 2-LED shift engines and RGB colour steering). It synchronizes and debounces the physical or VIO-muxed buttons and switches, and turns button presses into single-cycle events. From those events it drives the pattern-mode FSM and the colour register, and it generates the step-enable tick (o_valid) that paces the pattern engines. It sits between the board/VIO input mux and the pattern engines plus the output colour mux.

Parameters:
NB_BTN, 4, number of buttons (bit0 = mode, bits1..3 = red/green/blue select)
NB_SW, 4, number of switches (bits2:0 = speed select, bit3 = reverse)
NB_DEBOUNCE, 20, width of each debounce counter
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (must fit NB_DEBOUNCE)
NB_COUNTER, 32, width of the tick counter
BASE_PERIOD, 1000000, tick period in clocks at speed 0 (BASE_PERIOD<<7 must fit NB_COUNTER)

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_btn  in  NB_BTN  raw buttons, asynchronous to clock
i_sw  in  NB_SW  raw switches, asynchronous to clock
o_valid  out  1  one-cycle step tick to the pattern engines
o_mode  out  2  00 flash, 01 shift, 10 shift2led; 11 never driven
o_color  out  2  00 red, 01 green, 10 blue; 11 never driven
o_reverse  out  1  registered, synchronized i_sw[3]
o_clear  out  1  one-cycle pulse on a mode change; engines reinitialize
o_btn_pulse  out  NB_BTN  one-cycle rising-edge events of the debounced buttons (debug/ILA)

Behaviour:
- Reset (i_reset=0, asynchronous) clears all flops. All outputs read 0: mode flash, colour red, tick counter 0, debounced state 0, synchronizers 0. Release is synchronous to clock.
- Synchronization: every i_btn and i_sw bit passes through a 2-flop synchronizer.
- Debounce (per button):
  - Counter cnt resets to 0 whenever the synchronized input equals the stable state.
  - Otherwise cnt increments each cycle.
  - When cnt reaches DEBOUNCE_CYCLES-1, the stable state takes the new level and cnt returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change.
- Edge detect: o_btn_pulse[i] is registered and high for exactly one cycle after stable[i] goes 0->1. There is no event on release.
  - Latency: a clean rising raw input held steady gives o_btn_pulse high at the DEBOUNCE_CYCLES+3rd rising edge after the first edge that samples it high.
  - A held button produces exactly one pulse.
- Mode FSM: FLASH(00) -> SHIFT(01) -> SHIFT2(10) -> FLASH, advancing on o_btn_pulse[0].
  - o_mode updates at the edge after the pulse.
  - o_clear is high for that same single cycle, i.e. the first cycle the new o_mode is visible.
- Colour:
  - On a pulse of bit1, bit2 or bit3, o_color becomes 00, 01 or 10 respectively, one cycle after the pulse.
  - If several colour pulses occur in the same cycle, the lowest index wins (bit1 > bit2 > bit3).
  - With no colour pulse, o_color holds.
  - Mode and colour events in the same cycle are both applied.
- Tick generator:
  - period = BASE_PERIOD << sw_sync[2:0].
  - cnt_tick counts 0..period-1; o_valid=1 in the cycle cnt_tick==period-1, then cnt_tick wraps to 0.
  - If sw_sync[2:0] differs from its value on the previous cycle, cnt_tick is forced to 0 and no tick is issued that cycle.
  - In the cycle o_clear=1, cnt_tick is 0 and o_valid=0, so the first tick of the new mode comes a full period later.
- o_reverse = sw_sync[3] delayed one register; no debounce.
- Reset mid-operation: the FSM, colour and counters return to reset values immediately. A button held through reset release produces a pulse after debounce, because the stable state restarts at 0.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, BASE_PERIOD=4.
- Reset release, no input -> o_mode=00, o_color=00, o_clear=0; o_valid high every 4th cycle (sel=0), first at cycle 4 after release.
- Assert i_btn[0] clean and hold for 20 cycles -> single o_btn_pulse[0] at edge 7. o_mode=01 and o_clear=1 at edge 8. Repeat press twice more -> mode 10, then 00.
- Toggle i_btn[2] high for 3 cycles, then low -> no pulse, o_color stays 00. Hold it for 10 cycles -> o_color=01.
- Press btn1 and btn3 in the same cycle -> o_color=00. Press btn0 and btn3 together -> o_mode advances and o_color=10 on the same edge.
- i_sw[2:0]=3 -> after the sync delay cnt_tick restarts; ticks every 32 cycles. Change to 0 mid-period -> no stray tick; next tick 4 cycles after the change is seen.
- Drive i_reset=0 asynchronously mid-period with mode=10, colour=10 -> outputs go to 0 before the next clock edge. After release the tick period restarts from 0.
